// File: rtl/qe_result_fifo.sv
// ---------------------------------------------------------------------------
// qe_result_fifo
//
// Output stage for the quadratic-equation / product-sum MAC. It captures every
// result the MAC qualifies with valid_out, together with the mode and
// end-of-sequence tag, and buffers it in a small first-word-fall-through FIFO.
// The host reads results on a ready/valid interface. The MAC cannot be stalled,
// so a result that arrives while the FIFO is full and not draining is dropped.
// Each drop is counted and also raises a sticky overflow flag.
//
// Ports:
//   clk           system clock, rising-edge active
//   reset         synchronous active-high reset
//   clear         synchronous flush of contents and status (same as reset)
//   mac_valid     result strobe from the MAC
//   mac_result    MAC result [DW-1:0]
//   mac_mode      mode tag (0 = quadratic, 1 = product sum)
//   mac_last      result closes a sequence
//   out_valid     head entry available
//   out_ready     consumer accepts head entry
//   out_data      head entry result [DW-1:0]
//   out_mode      head entry mode tag
//   out_last      head entry last tag
//   level         occupancy 0..DEPTH [AW:0]
//   full          level == DEPTH
//   overflow      sticky: at least one result dropped since reset/clear
//   drop_count    dropped results, saturating at 255
//   result_count  accepted results, wraps modulo 2^16
// ---------------------------------------------------------------------------
module qe_result_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          mac_valid,
    input  logic [DW-1:0] mac_result,
    input  logic          mac_mode,
    input  logic          mac_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_mode,
    output logic          out_last,
    output logic [AW:0]   level,
    output logic          full,
    output logic          overflow,
    output logic [7:0]    drop_count,
    output logic [15:0]   result_count
);

    localparam int          EW        = DW + 2;
    localparam logic [AW:0] FULL_LVL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE   = (AW + 1)'(1);
    localparam logic [AW:0] LVL_ZERO  = (AW + 1)'(0);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);

    // Storage entry layout: {last, mode, result}
    logic [EW-1:0] mem_r [DEPTH];

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic          overflow_r;
    logic [7:0]    drop_count_r;
    logic [15:0]   result_count_r;

    logic          flush_s;
    logic          valid_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic [EW-1:0] head_s;

    // Handshake qualification: push may use the slot freed by a same-cycle pop
    always_comb begin
        flush_s = reset | clear;
        valid_s = (level_r != LVL_ZERO);
        full_s  = (level_r == FULL_LVL);
        pop_s   = valid_s & out_ready;
        push_s  = mac_valid & (~full_s | pop_s);
        drop_s  = mac_valid & full_s & ~pop_s;
        head_s  = mem_r[rd_ptr_r];
    end

    // Payload memory; not reset, and a write in a flush cycle is suppressed
    always_ff @(posedge clk) begin
        if (push_s && !flush_s) begin
            mem_r[wr_ptr_r] <= {mac_last, mac_mode, mac_result};
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2**AW
    always_ff @(posedge clk) begin
        if (flush_s) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Status counters: sticky overflow, saturating drops, wrapping accepts
    always_ff @(posedge clk) begin
        if (flush_s) begin
            overflow_r     <= 1'b0;
            drop_count_r   <= 8'd0;
            result_count_r <= 16'd0;
        end else begin
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_count_r != 8'hFF) begin
                    drop_count_r <= drop_count_r + 8'd1;
                end else begin
                    drop_count_r <= drop_count_r;
                end
            end else begin
                overflow_r   <= overflow_r;
                drop_count_r <= drop_count_r;
            end
            if (push_s) begin
                result_count_r <= result_count_r + 16'd1;
            end else begin
                result_count_r <= result_count_r;
            end
        end
    end

    // Output mapping; head fields fall through from the read pointer
    always_comb begin
        out_valid    = valid_s;
        full         = full_s;
        out_data     = head_s[DW-1:0];
        out_mode     = head_s[DW];
        out_last     = head_s[DW+1];
        level        = level_r;
        overflow     = overflow_r;
        drop_count   = drop_count_r;
        result_count = result_count_r;
    end

endmodule

// File: tb/tb_qe_result_fifo.sv
module tb_qe_result_fifo;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        mac_valid;
    logic [15:0] mac_result;
    logic        mac_mode;
    logic        mac_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_mode;
    logic        out_last;
    logic [3:0]  level;
    logic        full;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [15:0] result_count;

    int checks_r;
    int errors_r;

    qe_result_fifo #(.DEPTH(8), .AW(3), .DW(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .mac_valid    (mac_valid),
        .mac_result   (mac_result),
        .mac_mode     (mac_mode),
        .mac_last     (mac_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_mode     (out_mode),
        .out_last     (out_last),
        .level        (level),
        .full         (full),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .result_count (result_count)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (got !== exp) begin
            errors_r = errors_r + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [15:0] d, input logic m, input logic l);
        mac_valid  = 1'b1;
        mac_result = d;
        mac_mode   = m;
        mac_last   = l;
        tick();
        mac_valid  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        checks_r   = 0;
        errors_r   = 0;
        reset      = 1'b1;
        clear      = 1'b0;
        mac_valid  = 1'b0;
        mac_result = 16'h0000;
        mac_mode   = 1'b0;
        mac_last   = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_rcnt", 32'(result_count), 32'd0);

        // Single pass, ready held high; no same-cycle bypass
        out_ready  = 1'b1;
        mac_valid  = 1'b1;
        mac_result = 16'h1234;
        mac_mode   = 1'b0;
        mac_last   = 1'b0;
        chk("sp_nobypass", 32'(out_valid), 32'd0);
        tick();
        mac_valid = 1'b0;
        chk("sp_valid", 32'(out_valid), 32'd1);
        chk("sp_data", 32'(out_data), 32'h1234);
        chk("sp_mode", 32'(out_mode), 32'd0);
        tick();
        chk("sp_level", 32'(level), 32'd0);
        chk("sp_rcnt", 32'(result_count), 32'd1);
        chk("sp_empty", 32'(out_valid), 32'd0);

        // Fill and drop
        out_ready = 1'b0;
        do_clear();
        for (int i = 1; i <= 10; i++) begin
            push_one(16'(i), 1'b0, 1'b0);
            if (i == 7) chk("fd_notfull7", 32'(full), 32'd0);
            if (i == 8) chk("fd_full8", 32'(full), 32'd1);
        end
        chk("fd_level", 32'(level), 32'd8);
        chk("fd_ovf", 32'(overflow), 32'd1);
        chk("fd_drop", 32'(drop_count), 32'd2);
        chk("fd_rcnt", 32'(result_count), 32'd8);
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk("fd_dvalid", 32'(out_valid), 32'd1);
            chk("fd_ddata", 32'(out_data), 32'(k));
            tick();
        end
        chk("fd_empty", 32'(out_valid), 32'd0);
        chk("fd_endlvl", 32'(level), 32'd0);
        chk("fd_drophold", 32'(drop_count), 32'd2);

        // Full with simultaneous pop and push
        out_ready = 1'b0;
        do_clear();
        for (int i = 1; i <= 8; i++) push_one(16'(i), 1'b0, 1'b0);
        out_ready  = 1'b1;
        mac_valid  = 1'b1;
        mac_result = 16'd9;
        chk("fp_popped", 32'(out_data), 32'd1);
        tick();
        mac_valid = 1'b0;
        out_ready = 1'b0;
        chk("fp_level", 32'(level), 32'd8);
        chk("fp_full", 32'(full), 32'd1);
        chk("fp_drop", 32'(drop_count), 32'd0);
        chk("fp_ovf", 32'(overflow), 32'd0);
        chk("fp_rcnt", 32'(result_count), 32'd9);
        out_ready = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            chk("fp_ddata", 32'(out_data), 32'(k));
            tick();
        end
        chk("fp_empty", 32'(out_valid), 32'd0);

        // Tags travel with their data
        out_ready = 1'b0;
        do_clear();
        push_one(16'h0005, 1'b1, 1'b0);
        push_one(16'h00FF, 1'b1, 1'b1);
        chk("tg_d0", 32'(out_data), 32'h0005);
        chk("tg_m0", 32'(out_mode), 32'd1);
        chk("tg_l0", 32'(out_last), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("tg_d1", 32'(out_data), 32'h00FF);
        chk("tg_m1", 32'(out_mode), 32'd1);
        chk("tg_l1", 32'(out_last), 32'd1);
        tick();
        chk("tg_empty", 32'(out_valid), 32'd0);

        // Clear mid-operation: 5 entries with overflow set
        out_ready = 1'b0;
        do_clear();
        for (int i = 1; i <= 9; i++) push_one(16'(i), 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        chk("cl_pre_level", 32'(level), 32'd5);
        chk("cl_pre_ovf", 32'(overflow), 32'd1);
        chk("cl_pre_head", 32'(out_data), 32'd4);
        clear      = 1'b1;
        mac_valid  = 1'b1;
        mac_result = 16'hAAAA;
        tick();
        clear     = 1'b0;
        mac_valid = 1'b0;
        chk("cl_level", 32'(level), 32'd0);
        chk("cl_valid", 32'(out_valid), 32'd0);
        chk("cl_ovf", 32'(overflow), 32'd0);
        chk("cl_drop", 32'(drop_count), 32'd0);
        chk("cl_rcnt", 32'(result_count), 32'd0);
        tick();
        chk("cl_nowrite", 32'(out_valid), 32'd0);

        // Wrap and drop-count saturation
        for (int i = 1; i <= 8; i++) push_one(16'(i), 1'b0, 1'b0);
        mac_valid = 1'b1;
        for (int i = 9; i <= 308; i++) begin
            mac_result = 16'(i);
            tick();
        end
        mac_valid = 1'b0;
        chk("ws_drop", 32'(drop_count), 32'd255);
        chk("ws_ovf", 32'(overflow), 32'd1);
        chk("ws_rcnt8", 32'(result_count), 32'd8);
        out_ready = 1'b1;
        mac_valid = 1'b1;
        for (int j = 0; j < 20; j++) begin
            mac_result = 16'(1000 + j);
            chk("ws_rate1", 32'(out_data), (j < 8) ? 32'(j + 1) : 32'(1000 + j - 8));
            tick();
        end
        mac_valid = 1'b0;
        chk("ws_level", 32'(level), 32'd8);
        chk("ws_rcnt28", 32'(result_count), 32'd28);
        chk("ws_dropsat", 32'(drop_count), 32'd255);
        for (int j = 12; j < 20; j++) begin
            chk("ws_tail", 32'(out_data), 32'(1000 + j));
            tick();
        end
        chk("ws_empty", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
